seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_scan_ctrl_if.sv | 14 +
 rtl/seg_hex_decode.sv | 13 +
 rtl/seg_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants, types and the hex-to-segment table for the 4-digit
// multiplexed seven-segment scanner.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [3:0]  AN_OFF     = 4'hF;

  // Active-low segments g..a, a=bit0; index 15 (F) listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } frame_t;

  localparam frame_t FRAME_RST = '{data: '0, dp: '0, blank: '1};

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-write handshake between a display writer and seg_scan_ctrl.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [4*NUM_DIGITS-1:0] wr_data;
  logic [NUM_DIGITS-1:0]   wr_dp;
  logic [NUM_DIGITS-1:0]   wr_blank;

  modport master (output wr_valid, wr_data, wr_dp, wr_blank, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_dp, wr_blank, output wr_ready);

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nib_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with a one-deep pending frame buffer.
// Optional blink support is compiled in when SEG_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_ctrl_if.slave        wr,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int unsigned    PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [1:0]              idx_q, idx_d;
  frame_t                  pend_q, pend_d, disp_q, disp_d;
  logic                    pend_full_q, pend_full_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;
  logic                    tick, boundary, accept, blanked;
  logic [3:0]              nib;
  logic [6:0]              nib_seg;

`ifdef SEG_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);
  logic [7:0] fcnt_q, fcnt_d;
  logic       phase_q, phase_d;
`endif

  seg_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

  assign wr.wr_ready = !pend_full_q;
  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_done  = fd_q;

  always_comb begin
    tick        = (presc_q == PRESC_LAST);
    boundary    = tick && (idx_q == 2'(NUM_DIGITS - 1));
    accept      = wr.wr_valid && !pend_full_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = tick ? idx_q + 1'b1 : idx_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    // Commit and accept are exclusive: accept needs pending empty.
    if (boundary && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = '{data: wr.wr_data, dp: wr.wr_dp, blank: wr.wr_blank};
      pend_full_d = 1'b1;
    end

    nib     = disp_q.data[{idx_q, 2'b00} +: 4];
    blanked = disp_q.blank[idx_q];
`ifdef SEG_BLINK_EN
    blanked = blanked | (phase_q & blink_mask[idx_q]);
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (fcnt_q == BLINK_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + 1'b1;
      end
    end
`endif

    an_d  = (presc_q == '0 || blanked) ? AN_OFF : ~(4'b0001 << idx_q);
    seg_d = blanked ? SEG_OFF : {~disp_q.dp[idx_q], nib_seg};
    fd_d  = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      disp_q      <= FRAME_RST;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      fd_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

`ifdef SEG_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV=4, BLINK_DIV=2); blink steps
// are exercised when SEG_BLINK_EN is defined.
module tb_seg_scan_ctrl;

  localparam int unsigned SD   = 4;
  localparam int unsigned BD   = 2;
  localparam int unsigned FLEN = 4 * SD;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } wf_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_done;
  logic [3:0] blink_mask = 4'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl_if wr_if ();

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_if.slave),
`ifdef SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: edges since reset release, shown frame, pending frame.
  int   k;
  int   nframes;
  wf_t  shown;
  wf_t  pend;
  logic p_full;
  wf_t  wq [$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    nframes = 0;
    shown   = '{data: 16'h0, dp: 4'h0, blank: 4'hF};
    pend    = '0;
    p_full  = 1'b0;
    wq.delete();
  endtask

  function automatic wf_t rand_frame();
    wf_t f;
    f.data  = 16'($urandom);
    f.dp    = 4'($urandom);
    f.blank = 4'($urandom) & 4'($urandom);
    return f;
  endfunction

  task automatic step();
    int         p, pr, ix;
    logic       phase, blk, bnd, acc;
    logic [3:0] onehot, e_an;
    logic [7:0] e_seg;
    if (wq.size() > 0) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = wq[0].data;
      wr_if.wr_dp    = wq[0].dp;
      wr_if.wr_blank = wq[0].blank;
    end else begin
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = 16'($urandom);
      wr_if.wr_dp    = 4'($urandom);
      wr_if.wr_blank = 4'($urandom);
    end
    @(posedge clk);
    p      = k % FLEN;
    pr     = p % SD;
    ix     = p / SD;
    phase  = ((nframes / BD) % 2) == 1;
    blk    = shown.blank[ix] | (phase & blink_mask[ix]);
    onehot = 4'b0001 << ix;
    e_an   = (pr == 0 || blk) ? 4'hF : ~onehot;
    e_seg  = blk ? 8'hFF : {~shown.dp[ix], hex_tab[shown.data[ix*4 +: 4]]};
    bnd    = (p == FLEN - 1);
    acc    = wr_if.wr_valid && !p_full;
    if (bnd) begin
      nframes++;
      if (p_full) begin
        shown  = pend;
        p_full = 1'b0;
      end
    end
    if (acc) begin
      pend   = wq.pop_front();
      p_full = 1'b1;
    end
    k++;
    #1;
    check("seg", seg, e_seg);
    check("an", 8'(an), 8'(e_an));
    check("frame_done", 8'(frame_done), 8'(bnd));
    check("wr_ready", 8'(wr_if.wr_ready), 8'(!p_full));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 * FLEN && wq.size() > 0; i++) step();
    check(tag, 8'(wq.size()), 8'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, seg, 8'hFF);
    check({tag, "_an"}, 8'(an), 8'h0F);
    check({tag, "_fd"}, 8'(frame_done), 8'd0);
    check({tag, "_rdy"}, 8'(wr_if.wr_ready), 8'd1);
  endtask

  initial begin
    bit found;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    wr_if.wr_dp    = '0;
    wr_if.wr_blank = '0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: dark display, periodic frame_done.
    run(3 * FLEN);

    // Directed frame 12AF with dp on digit 0.
    wq.push_back('{data: 16'h12AF, dp: 4'b0001, blank: 4'h0});
    run(3 * FLEN);

    // Two frames back-to-back with wr_valid held.
    wq.push_back('{data: 16'h3C5E, dp: 4'b1010, blank: 4'h0});
    wq.push_back('{data: 16'h9071, dp: 4'b0100, blank: 4'h0});
    drain("b2b_drain");
    run(2 * FLEN);

    // Digit 2 blanked.
    wq.push_back('{data: 16'h4D8B, dp: 4'b1111, blank: 4'b0100});
    run(3 * FLEN);

    // Random frames with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      wq.push_back(rand_frame());
      run(int'($urandom_range(1, 40)));
    end
    drain("rand_drain");
    run(FLEN);

    // Reset in the middle of slot 2 with a frame pending.
    found = 1'b0;
    for (int i = 0; i < 8 * FLEN && !found; i++) begin
      if (wq.size() == 0 && !p_full) wq.push_back(rand_frame());
      step();
      if (p_full && ((k % FLEN) / SD) == 2 && (k % SD) == 2) found = 1'b1;
    end
    check("midreset_found", 8'(found), 8'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    run(3 * FLEN);

`ifdef SEG_BLINK_EN
    blink_mask = 4'b0001;
`endif
    wq.push_back('{data: 16'h8A10, dp: 4'b0011, blank: 4'h0});
    run(9 * FLEN);
`ifdef SEG_BLINK_EN
    blink_mask = 4'($urandom);
`endif
    wq.push_back(rand_frame());
    run(5 * FLEN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
